mux_lane_sched: RTL and testbench

//  Round-robin scheduler for the registered 4:1 lane mux (8-bit X, 2-bit select Y, registered 2-bit F).

---
 rtl/mux_lane_sched_if.sv | 37 +++
 rtl/mux_lane_sched.sv | 113 +++++++++++
 tb/tb_mux_lane_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mux_lane_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_lane_sched_if
// Purpose  : Bundle of request, mux-select, mux-result and output-handshake
//            signals between the lane scheduler and its surroundings.
// Revision : 1.0  initial release
// ============================================================================
interface mux_lane_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int LANE_W  = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0] req;
  logic [SEL_W-1:0]   sel;
  logic [LANE_W-1:0]  mux_f;
  logic               out_valid;
  logic               out_ready;
  logic [LANE_W-1:0]  out_data;
  logic [SEL_W-1:0]   out_lane;
  logic [NUM_REQ-1:0] ack;
  logic               busy;
  logic [CNT_W-1:0]   xfer_cnt;

  // Scheduler side
  modport master (
    input  req, mux_f, out_ready,
    output sel, out_valid, out_data, out_lane, ack, busy, xfer_cnt
  );

  // Requesters / mux / downstream side
  modport slave (
    output req, mux_f, out_ready,
    input  sel, out_valid, out_data, out_lane, ack, busy, xfer_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mux_lane_sched.sv
`default_nettype none
// ============================================================================
// Module   : mux_lane_sched
// Purpose  : Round-robin scheduler in front of a registered 4:1 lane mux.
//            Grants one requester, steers the mux select, waits out the mux
//            register latency, presents the captured lane on a valid/ready
//            output and pulses a one-hot ack when the handshake completes.
// Revision : 1.0  initial release
// ============================================================================
module mux_lane_sched #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int LANE_W  = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  mux_lane_sched_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEL  = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   sel_q;
  logic               out_valid_q;
  logic [LANE_W-1:0]  out_data_q;
  logic [SEL_W-1:0]   out_lane_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0] eff;
  logic               win_found;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   scan_idx;

  // The lane being acked this cycle still shows its request; mask it so it
  // cannot be re-granted before the requester has seen the ack.
  assign eff = bus.req & ~ack_q;

  // Rotating priority search: first eligible lane starting at ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ptr_q + SEL_W'(i);
      if (!win_found && eff[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Transfer sequencer: grant, wait for mux register, capture, handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      ack_q       <= '0;
      cnt_q       <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            sel_q      <= win_idx;
            out_lane_q <= win_idx;
            state_q    <= S_SEL;
          end
        end
        S_SEL: begin
          // Mux registers X[sel] at the end of this cycle.
          state_q <= S_CAP;
        end
        S_CAP: begin
          out_data_q  <= bus.mux_f;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ack_q       <= NUM_REQ'(1) << out_lane_q;
            ptr_q       <= out_lane_q + SEL_W'(1);
            cnt_q       <= cnt_q + CNT_W'(1);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_lane  = out_lane_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.xfer_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_lane_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_lane_sched
// Purpose  : Self-checking bench for mux_lane_sched with a registered 4:1 mux
//            model and a transaction-timeline reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_lane_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;

  always #5 clk = ~clk;

  mux_lane_sched_if #(.CNT_W(16)) bus  ();
  mux_lane_sched_if #(.CNT_W(2))  bus2 ();

  mux_lane_sched #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mux_lane_sched #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.req       = bus.req;
  assign bus2.out_ready = bus.out_ready;

  // Registered 4:1 lane mux, one per scheduler instance.
  always_ff @(posedge clk) begin
    bus.mux_f  <= x[{bus.sel, 1'b0}  +: 2];
    bus2.mux_f <= x[{bus2.sel, 1'b0} +: 2];
  end

  // ---------------- reference model (transfer timeline) ----------------
  int          t;
  bit          m_active;
  int          m_g;        // cycle in which the current transfer was granted
  logic [1:0]  m_lane;
  logic [1:0]  m_sel;
  logic [1:0]  m_ptr;
  logic [1:0]  m_pend;
  logic [1:0]  m_data;
  logic [3:0]  m_ack;
  int unsigned m_cnt;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, t, got, exp);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_g      = 0;
    m_lane   = 2'd0;
    m_sel    = 2'd0;
    m_ptr    = 2'd0;
    m_pend   = 2'd0;
    m_data   = 2'd0;
    m_ack    = 4'd0;
    m_cnt    = 0;
  endtask

  task automatic check_now();
    logic ev;
    ev = m_active && (t >= m_g + 3);
    chk("busy",      {31'd0, bus.busy},      {31'd0, m_active});
    chk("sel",       {30'd0, bus.sel},       {30'd0, m_sel});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
    chk("out_data",  {30'd0, bus.out_data},  {30'd0, m_data});
    chk("out_lane",  {30'd0, bus.out_lane},  {30'd0, m_lane});
    chk("ack",       {28'd0, bus.ack},       {28'd0, m_ack});
    chk("xfer_cnt",  {16'd0, bus.xfer_cnt},  m_cnt % 65536);
    chk("cnt_wrap",  {30'd0, bus2.xfer_cnt}, m_cnt % 4);
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq, input logic rdy,
                            input logic [7:0] xv);
    logic [3:0] eff;
    logic [3:0] nack;
    int         w;
    if (r) begin
      model_reset();
    end else begin
      nack = 4'd0;
      if (m_active) begin
        if (t == m_g + 1) m_pend = xv[2*m_lane +: 2];
        if (t == m_g + 2) m_data = m_pend;
        if (t >= m_g + 3 && rdy) begin
          nack     = 4'd1 << m_lane;
          m_ptr    = m_lane + 2'd1;
          m_cnt    = m_cnt + 1;
          m_active = 1'b0;
        end
      end else begin
        eff = rq & ~m_ack;
        w   = -1;
        for (int i = 0; i < 4; i++) begin
          if (w < 0 && eff[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
        end
        if (w >= 0) begin
          m_active = 1'b1;
          m_g      = t;
          m_sel    = 2'(w);
          m_lane   = 2'(w);
        end
      end
      m_ack = nack;
    end
    t++;
  endtask

  task automatic do_cycle(input logic r, input logic [3:0] rq, input logic rdy,
                          input logic [7:0] xv);
    @(negedge clk);
    check_now();
    rst           = r;
    bus.req       = rq;
    bus.out_ready = rdy;
    x             = xv;
    model_step(r, rq, rdy, xv);
  endtask

  initial begin
    t             = 0;
    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b0;
    x             = 8'h00;
    model_reset();

    // Reset with all requests pending
    repeat (2) do_cycle(1'b1, 4'b1111, 1'b0, 8'h00);

    // Single request on lane 2
    repeat (5) do_cycle(1'b0, 4'b0100, 1'b1, 8'b11_10_01_00);
    repeat (3) do_cycle(1'b0, 4'b0000, 1'b1, 8'b11_10_01_00);

    // All lanes requesting, full round-robin rotation
    repeat (22) do_cycle(1'b0, 4'b1111, 1'b1, 8'($urandom));
    repeat (4)  do_cycle(1'b0, 4'b0000, 1'b1, 8'($urandom));

    // Backpressure while X toggles
    repeat (14) do_cycle(1'b0, 4'b0001, 1'b0, 8'($urandom));
    do_cycle(1'b0, 4'b0001, 1'b1, 8'($urandom));
    repeat (6)  do_cycle(1'b0, 4'b0000, 1'b1, 8'($urandom));

    // Reset while in the capture cycle, then lanes 0 and 3 compete
    do_cycle(1'b0, 4'b0010, 1'b1, 8'($urandom));
    do_cycle(1'b0, 4'b0000, 1'b1, 8'($urandom));
    do_cycle(1'b1, 4'b0000, 1'b1, 8'($urandom));
    repeat (6) do_cycle(1'b0, 4'b1001, 1'b1, 8'($urandom));
    repeat (4) do_cycle(1'b0, 4'b0000, 1'b1, 8'($urandom));

    // Random traffic with occasional reset and random backpressure
    for (int k = 0; k < 400; k++) begin
      do_cycle(($urandom_range(0, 63) == 0),
               4'($urandom),
               1'($urandom),
               8'($urandom));
    end

    @(negedge clk);
    check_now();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
